// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code tracker.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam int PS2_MAX_KEYS = 16;
    localparam int PS2_TBL_W    = PS2_MAX_KEYS * 9;

    // {ext, scan byte}
    typedef logic [8:0] key_code_t;

    localparam key_code_t PS2_CODE_NONE = 9'h1FF;

    function automatic key_code_t key_slot(
        input logic [PS2_TBL_W-1:0] tbl,
        input int unsigned          idx
    );
        return tbl[idx*9 +: 9];
    endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Byte-receiver input and key-state output bundle of the tracker.
interface ps2_key_tracker_if #(
    parameter int NUM_KEYS = 6
);
    logic [7:0]          ps2_key_data;
    logic                ps2_key_pressed;
    logic [NUM_KEYS-1:0] key_held;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic                any_held;
    logic [8:0]          last_code;
    logic                last_is_break;
    logic                code_valid;

    modport master (
        output ps2_key_data,
        output ps2_key_pressed,
        input  key_held,
        input  key_press,
        input  key_release,
        input  any_held,
        input  last_code,
        input  last_is_break,
        input  code_valid
    );

    modport slave (
        input  ps2_key_data,
        input  ps2_key_pressed,
        output key_held,
        output key_press,
        output key_release,
        output any_held,
        output last_code,
        output last_is_break,
        output code_valid
    );

endinterface

// File: rtl/ps2_prefix_fsm.sv
// Set-2 E0/F0 prefix decoder with idle timeout; emits one strobe
// per completed make/break carrying {ext, byte}.
module ps2_prefix_fsm
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 150000
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic [7:0] byte_i,
    input  logic      stb_i,
    output logic      code_stb_o,
    output key_code_t code_o,
    output logic      is_break_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    ps2_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic is_ext;
    logic is_brk;
    logic expired;

    assign is_ext  = (byte_i == PS2_PREFIX_EXT);
    assign is_brk  = (byte_i == PS2_PREFIX_BRK);
    assign expired = (cnt_q >= CNT_MAX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A strobe always takes priority over a coincident expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (stb_i) begin
            cnt_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (is_ext) state_d = ST_EXT;
                    else if (is_brk) state_d = ST_BRK;
                end
                ST_EXT: begin
                    if (is_brk) state_d = ST_EXT_BRK;
                    else if (!is_ext) state_d = ST_IDLE;
                end
                ST_BRK:     state_d = ST_IDLE;
                ST_EXT_BRK: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (expired) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        code_stb_o = 1'b0;
        code_o     = {1'b0, byte_i};
        is_break_o = 1'b0;
        if (stb_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    code_stb_o = !is_ext && !is_brk;
                end
                ST_EXT: begin
                    code_stb_o = !is_ext && !is_brk;
                    code_o     = {1'b1, byte_i};
                end
                ST_BRK: begin
                    code_stb_o = 1'b1;
                    is_break_o = 1'b1;
                end
                ST_EXT_BRK: begin
                    code_stb_o = 1'b1;
                    code_o     = {1'b1, byte_i};
                    is_break_o = 1'b1;
                end
                default: code_stb_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Tracks held state of a configurable set of PS/2 keys and emits
// registered press/release pulses plus the last decoded code.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int                        NUM_KEYS       = 6,
    parameter logic [NUM_KEYS*9-1:0]     KEY_CODES      =
        {9'h175, 9'h029, 9'h023, 9'h01C, 9'h01B, 9'h01D},
    parameter key_code_t                 CLEAR_CODE     = 9'h015,
    parameter int                        TIMEOUT_CYCLES = 150000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    ps2_key_tracker_if.slave bus
);

    localparam logic [PS2_TBL_W-1:0] TBL = PS2_TBL_W'(KEY_CODES);
    localparam bit CLEAR_EN = (CLEAR_CODE != PS2_CODE_NONE);

    logic      code_stb;
    key_code_t code;
    logic      code_brk;

    logic [NUM_KEYS-1:0] held_q, held_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] rel_q, rel_d;
    logic                any_q, any_d;
    key_code_t           lc_q, lc_d;
    logic                lb_q, lb_d;
    logic                cv_q, cv_d;

    ps2_prefix_fsm #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fsm (
        .clk_i     (CLOCK_50),
        .rst_i     (reset),
        .byte_i    (bus.ps2_key_data),
        .stb_i     (bus.ps2_key_pressed),
        .code_stb_o(code_stb),
        .code_o    (code),
        .is_break_o(code_brk)
    );

    always_comb begin
        held_d  = held_q;
        press_d = '0;
        rel_d   = '0;
        lc_d    = lc_q;
        lb_d    = lb_q;
        cv_d    = 1'b0;
        if (code_stb) begin
            cv_d = 1'b1;
            lc_d = code;
            lb_d = code_brk;
            if (CLEAR_EN && !code_brk && (code == CLEAR_CODE)) begin
                rel_d  = held_q;
                held_d = '0;
            end else begin
                for (int i = 0; i < NUM_KEYS; i++) begin
                    if (key_slot(TBL, i) == code) begin
                        if (code_brk) begin
                            rel_d[i]  = held_q[i];
                            held_d[i] = 1'b0;
                        end else begin
                            press_d[i] = !held_q[i];
                            held_d[i]  = 1'b1;
                        end
                    end
                end
            end
        end
        any_d = |held_d;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            held_q  <= '0;
            press_q <= '0;
            rel_q   <= '0;
            any_q   <= 1'b0;
            lc_q    <= '0;
            lb_q    <= 1'b0;
            cv_q    <= 1'b0;
        end else begin
            held_q  <= held_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            any_q   <= any_d;
            lc_q    <= lc_d;
            lb_q    <= lb_d;
            cv_q    <= cv_d;
        end
    end

    assign bus.key_held      = held_q;
    assign bus.key_press     = press_q;
    assign bus.key_release   = rel_q;
    assign bus.any_held      = any_q;
    assign bus.last_code     = lc_q;
    assign bus.last_is_break = lb_q;
    assign bus.code_valid    = cv_q;

endmodule
